regfile_decode: RTL and testbench
=================================

REGFILE_DECODE -- requirements
Module: regfile_decode

Interface
REQ-001 SHALL have parameter RESET_REGS, default 1: 1 = rst clears all 31 GPRs; 0 = only the IF/ID register is cleared.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port StallD, input, 1: hold the IF/ID register.
REQ-005 SHALL have port FlushD, input, 1: bubble the IF/ID register.
REQ-006 SHALL have ports InstrF and PCPlus4F, input, 32 each: fetch-stage instruction and PC+4.
REQ-007 SHALL have writeback ports RegWriteW (input, 1), WriteRegW (input, 5) and ResultW (input, 32).
REQ-008 SHALL have ports ForwardAD and ForwardBD (input, 1 each) and ALUMultOutM (input, 32): M-stage branch-operand forwarding.
REQ-009 SHALL have ports InstrD and PCPlus4D, output, 32 each: registered IF/ID contents.
REQ-010 SHALL have ports RsD, RtD and RdD, output, 5 each: InstrD[25:21], [20:16] and [15:11].
REQ-011 SHALL have ports RD1D and RD2D, output, 32 each: register read data for Rs and Rt.
REQ-012 SHALL have port SignImmD, output, 32: InstrD[15:0] sign-extended.
REQ-013 SHALL have port jumpDstD, output, 28: {InstrD[25:0], 2'b00}.
REQ-014 SHALL have port EqualD, output, 1: branch comparator result.

Function
REQ-015 SHALL update IF/ID with priority rst > StallD > FlushD > load: StallD holds; FlushD alone loads InstrD=0 (sll nop) and PCPlus4D=0; otherwise loads InstrF/PCPlus4F.
REQ-016 SHALL give IF/ID a latency of exactly 1 cycle from F to D.
REQ-017 SHALL implement 32 x 32-bit GPRs with 1 write port (W) and 2 combinational read ports addressed by RsD and RtD.
REQ-018 SHALL write ResultW to GPR[WriteRegW] on the rising edge when RegWriteW=1 and WriteRegW!=0.
REQ-019 SHALL not be affected by StallD or FlushD when performing GPR writes.
REQ-020 SHALL ignore writes to $0 and always read $0 as 32'h0, including under bypass.
REQ-021 SHALL compute EqualD = (ForwardAD ? ALUMultOutM : RD1D) == (ForwardBD ? ALUMultOutM : RD2D).
REQ-022 SHALL be purely combinational from InstrD/GPR state for SignImmD, jumpDstD and the Rs/Rt/Rd fields.
REQ-023 SHALL keep the value of a register addressed on both read ports consistent across the two ports.

Reset
REQ-024 SHALL, on the clock edge with rst=1, clear InstrD and PCPlus4D to 0.
REQ-025 SHALL, on that same edge, clear GPR[1..31] to 0 if RESET_REGS=1 and leave them unchanged if RESET_REGS=0.
REQ-026 SHALL, while rst=1, ignore W-stage writes, StallD and FlushD.
REQ-027 SHALL resume normal operation on the first edge after rst deasserts, with no pending state.

Configuration
REQ-028 SHALL honour macro REGFILE_BYPASS_EN.
REQ-029 SHALL, when REGFILE_BYPASS_EN is defined, return ResultW on a read port whose address equals WriteRegW!=0 while RegWriteW=1, in the same cycle as the write (write-through).
REQ-030 SHALL, when REGFILE_BYPASS_EN is undefined, return the pre-write GPR value on that read; the hazard unit then stalls one extra cycle.

Structure
REQ-031 SHALL take constants NOP_INSTR (32'h0), REG_ZERO (5'd0) and REG_RA (5'd31), and the instruction field bit-position localparams, from shared package mips_pkg.
REQ-032 SHALL contain exactly one sub-module, regfile (GPR array with read and bypass logic); the IF/ID register and decode field logic SHALL stay in regfile_decode.

Verification
REQ-033 SHALL cover: rst for 1 cycle -> all outputs 0; InstrF=32'h8C22_0004 on the next edge -> RsD=1, RtD=2, SignImmD=32'h4.
REQ-034 SHALL cover: RegWriteW=1, WriteRegW=5, ResultW=32'hDEAD_BEEF with RsD=5 in the same cycle -> RD1D=DEADBEEF that cycle with bypass enabled, and on the following cycle without it.
REQ-035 SHALL cover: write 32'h1234 to $0, then read Rs=0 -> RD1D=0 in both the write cycle and afterwards.
REQ-036 SHALL cover: StallD=1 and FlushD=1 together with InstrF=32'h1111_1111 -> InstrD keeps its prior value; FlushD alone -> InstrD=0.
REQ-037 SHALL cover: RD1D=7, RD2D=9, ALUMultOutM=9, ForwardAD=1 -> EqualD=1; with ForwardAD=0 -> EqualD=0.
REQ-038 SHALL cover: rst asserted mid-stream with RESET_REGS=0 -> a previously written GPR[3]=32'hA5 still reads 32'hA5 after reset; with RESET_REGS=1 it reads 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS constants, instruction field positions and the IF/ID record.
package mips_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [4:0]  REG_RA    = 5'd31;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int JMP_MSB = 25;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } ifid_t;
  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction
endpackage

// File: rtl/regfile_decode_if.sv
// regfile_decode_if: fetch, writeback, forwarding and decode-stage signals of the D stage.
interface regfile_decode_if;
  logic        StallD, FlushD;
  logic [31:0] InstrF, PCPlus4F;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic        ForwardAD, ForwardBD;
  logic [31:0] ALUMultOutM;
  logic [31:0] InstrD, PCPlus4D;
  logic [4:0]  RsD, RtD, RdD;
  logic [31:0] RD1D, RD2D, SignImmD;
  logic [27:0] jumpDstD;
  logic        EqualD;
  modport master (
    output StallD, FlushD, InstrF, PCPlus4F, RegWriteW, WriteRegW, ResultW,
           ForwardAD, ForwardBD, ALUMultOutM,
    input  InstrD, PCPlus4D, RsD, RtD, RdD, RD1D, RD2D, SignImmD, jumpDstD, EqualD
  );
  modport slave (
    input  StallD, FlushD, InstrF, PCPlus4F, RegWriteW, WriteRegW, ResultW,
           ForwardAD, ForwardBD, ALUMultOutM,
    output InstrD, PCPlus4D, RsD, RtD, RdD, RD1D, RD2D, SignImmD, jumpDstD, EqualD
  );
endinterface

// File: rtl/regfile.sv
// regfile: 31 GPRs plus hardwired $0, one write port, two combinational read ports.
// Defining REGFILE_BYPASS_EN makes reads see a same-cycle W-stage write (write-through).
module regfile
  import mips_pkg::*;
#(
  parameter bit RESET_REGS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] gpr [1:31];
  always_ff @(posedge clk) begin
    if (rst) begin
      if (RESET_REGS)
        for (int i = 1; i < 32; i++) gpr[i] <= '0;
    end else if (we && wa != REG_ZERO) gpr[wa] <= wd;
  end
`ifdef REGFILE_BYPASS_EN
  assign rd1 = ra1 == REG_ZERO ? '0 : (we && wa == ra1) ? wd : gpr[ra1];
  assign rd2 = ra2 == REG_ZERO ? '0 : (we && wa == ra2) ? wd : gpr[ra2];
`else
  assign rd1 = ra1 == REG_ZERO ? '0 : gpr[ra1];
  assign rd2 = ra2 == REG_ZERO ? '0 : gpr[ra2];
`endif
endmodule

// File: rtl/regfile_decode.sv
// regfile_decode: IF/ID pipeline register, field decode, GPR read and branch compare.
// Optional write-through read path selected by macro REGFILE_BYPASS_EN (inside regfile).
module regfile_decode
  import mips_pkg::*;
#(
  parameter bit RESET_REGS = 1
) (
  input  logic                clk,
  input  logic                rst,
  regfile_decode_if.slave     bus
);
  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0};
  ifid_t       ifid;
  logic [31:0] rd1, rd2;
  always_ff @(posedge clk) begin
    if (rst) ifid <= BUBBLE;
    else if (!bus.StallD) ifid <= bus.FlushD ? BUBBLE : '{instr: bus.InstrF, pc_plus4: bus.PCPlus4F};
  end
  regfile #(.RESET_REGS(RESET_REGS)) u_regfile (
    .clk (clk),
    .rst (rst),
    .we  (bus.RegWriteW),
    .wa  (bus.WriteRegW),
    .wd  (bus.ResultW),
    .ra1 (ifid.instr[RS_LSB +: 5]),
    .ra2 (ifid.instr[RT_LSB +: 5]),
    .rd1 (rd1),
    .rd2 (rd2)
  );
  assign bus.InstrD   = ifid.instr;
  assign bus.PCPlus4D = ifid.pc_plus4;
  assign bus.RsD      = ifid.instr[RS_LSB +: 5];
  assign bus.RtD      = ifid.instr[RT_LSB +: 5];
  assign bus.RdD      = ifid.instr[RD_LSB +: 5];
  assign bus.RD1D     = rd1;
  assign bus.RD2D     = rd2;
  assign bus.SignImmD = sign_ext16(ifid.instr[IMM_MSB:0]);
  assign bus.jumpDstD = {ifid.instr[JMP_MSB:0], 2'b00};
  assign bus.EqualD   = (bus.ForwardAD ? bus.ALUMultOutM : rd1) == (bus.ForwardBD ? bus.ALUMultOutM : rd2);
endmodule

// File: tb/tb_regfile_decode.sv
// tb_regfile_decode: directed and random checks of regfile_decode (both RESET_REGS values) against a behavioural model.
module tb_regfile_decode;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1;
`else
  localparam bit BYP = 0;
`endif
  logic clk = 0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  regfile_decode_if b1 ();
  regfile_decode_if b0 ();
  regfile_decode #(.RESET_REGS(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  regfile_decode #(.RESET_REGS(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  assign b0.StallD      = b1.StallD;
  assign b0.FlushD      = b1.FlushD;
  assign b0.InstrF      = b1.InstrF;
  assign b0.PCPlus4F    = b1.PCPlus4F;
  assign b0.RegWriteW   = b1.RegWriteW;
  assign b0.WriteRegW   = b1.WriteRegW;
  assign b0.ResultW     = b1.ResultW;
  assign b0.ForwardAD   = b1.ForwardAD;
  assign b0.ForwardBD   = b1.ForwardBD;
  assign b0.ALUMultOutM = b1.ALUMultOutM;
  always #5 clk = ~clk;

  logic [31:0] m_instr, m_pc;
  logic [31:0] m1 [32];
  logic [31:0] m0 [32];
  bit          k0 [32];

  function automatic bool_known(input bit rr, input int a);
    return rr || a == 0 || k0[a] || (BYP && b1.RegWriteW && int'(b1.WriteRegW) == a);
  endfunction

  function automatic logic [31:0] mrd(input bit rr, input int a);
    if (a == 0) return 32'h0;
    if (BYP && b1.RegWriteW && int'(b1.WriteRegW) == a) return b1.ResultW;
    return rr ? m1[a] : m0[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string n, input bit rr, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                         input logic [27:0] jd, input logic eq);
    int ers, ert, erd;
    logic [31:0] eimm, ea, eb;
    ers  = int'((m_instr >> 21) % 32);
    ert  = int'((m_instr >> 16) % 32);
    erd  = int'((m_instr >> 11) % 32);
    eimm = m_instr % 65536;
    if (eimm >= 32768) eimm = eimm + 32'hFFFF_0000;
    chk({n, ".instr"}, instr, m_instr);
    chk({n, ".pc4"}, pc, m_pc);
    chk({n, ".rs"}, {27'd0, rs}, ers);
    chk({n, ".rt"}, {27'd0, rt}, ert);
    chk({n, ".rd"}, {27'd0, rd}, erd);
    chk({n, ".imm"}, imm, eimm);
    chk({n, ".jdst"}, {4'd0, jd}, (m_instr % (1 << 26)) * 4);
    if (bool_known(rr, ers)) chk({n, ".rd1"}, r1, mrd(rr, ers));
    if (bool_known(rr, ert)) chk({n, ".rd2"}, r2, mrd(rr, ert));
    if (bool_known(rr, ers) && bool_known(rr, ert)) begin
      ea = b1.ForwardAD ? b1.ALUMultOutM : mrd(rr, ers);
      eb = b1.ForwardBD ? b1.ALUMultOutM : mrd(rr, ert);
      chk({n, ".eq"}, {31'd0, eq}, {31'd0, ea == eb});
    end
  endtask

  task automatic model_reset();
    m_instr = 0;
    m_pc = 0;
    for (int r = 0; r < 32; r++) m1[r] = 0;
  endtask

  task automatic tick();
    int w;
    #2;
    chk_dut("d1", 1, b1.InstrD, b1.PCPlus4D, b1.RsD, b1.RtD, b1.RdD, b1.RD1D, b1.RD2D, b1.SignImmD, b1.jumpDstD, b1.EqualD);
    chk_dut("d0", 0, b0.InstrD, b0.PCPlus4D, b0.RsD, b0.RtD, b0.RdD, b0.RD1D, b0.RD2D, b0.SignImmD, b0.jumpDstD, b0.EqualD);
    if (rst) model_reset();
    else begin
      if (!b1.StallD) begin
        m_instr = b1.FlushD ? 32'h0 : b1.InstrF;
        m_pc    = b1.FlushD ? 32'h0 : b1.PCPlus4F;
      end
      w = int'(b1.WriteRegW);
      if (b1.RegWriteW && w != 0) begin
        m1[w] = b1.ResultW;
        m0[w] = b1.ResultW;
        k0[w] = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    b1.StallD = 0; b1.FlushD = 0; b1.InstrF = 0; b1.PCPlus4F = 0;
    b1.RegWriteW = 0; b1.WriteRegW = 0; b1.ResultW = 0;
    b1.ForwardAD = 0; b1.ForwardBD = 0; b1.ALUMultOutM = 0;
    for (int r = 0; r < 32; r++) k0[r] = 0;
    m0[0] = 0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 0;
    // after a one-cycle reset every output is zero; then a lw is decoded
    b1.InstrF = 32'h8C22_0004; b1.PCPlus4F = 32'h4;
    tick();
    chk("lw.rs", {27'd0, b1.RsD}, 32'd1);
    chk("lw.rt", {27'd0, b1.RtD}, 32'd2);
    chk("lw.imm", b1.SignImmD, 32'h4);
    b1.InstrF = 0;
    for (int r = 1; r < 32; r++) begin
      b1.RegWriteW = 1; b1.WriteRegW = 5'(r); b1.ResultW = $urandom;
      tick();
    end
    b1.RegWriteW = 0;
    b1.InstrF = 32'd5 << 21;
    tick();
    b1.RegWriteW = 1; b1.WriteRegW = 5; b1.ResultW = 32'hDEAD_BEEF;
    #1 chk("byp.same", b1.RD1D, BYP ? 32'hDEAD_BEEF : m1[5]);
    #0 tick();
    b1.RegWriteW = 0;
    #1 chk("byp.next", b1.RD1D, 32'hDEAD_BEEF);
    #0 b1.InstrF = 0;
    tick();
    b1.RegWriteW = 1; b1.WriteRegW = 0; b1.ResultW = 32'h1234;
    #1 chk("r0.same", b1.RD1D, 32'h0);
    #0 tick();
    b1.RegWriteW = 0;
    tick();
    chk("r0.after", b1.RD1D, 32'h0);
    b1.InstrF = 32'h2222_2222;
    tick();
    b1.StallD = 1; b1.FlushD = 1; b1.InstrF = 32'h1111_1111;
    tick();
    chk("stall.hold", b1.InstrD, 32'h2222_2222);
    b1.StallD = 0;
    tick();
    chk("flush.nop", b1.InstrD, 32'h0);
    b1.FlushD = 0;
    b1.RegWriteW = 1; b1.WriteRegW = 1; b1.ResultW = 7;
    tick();
    b1.WriteRegW = 2; b1.ResultW = 9; b1.InstrF = (32'd1 << 21) | (32'd2 << 16);
    tick();
    b1.RegWriteW = 0; b1.ALUMultOutM = 9; b1.ForwardAD = 1;
    #1 chk("eq.fwd", {31'd0, b1.EqualD}, 32'd1);
    #0 b1.ForwardAD = 0;
    #1 chk("eq.nofwd", {31'd0, b1.EqualD}, 32'd0);
    #0 tick();
    b1.RegWriteW = 1; b1.WriteRegW = 3; b1.ResultW = 32'hA5; b1.InstrF = 32'd3 << 21;
    tick();
    rst = 1; b1.WriteRegW = 4; b1.ResultW = 32'hFFFF; b1.StallD = 1;
    tick();
    rst = 0; b1.RegWriteW = 0; b1.StallD = 0;
    tick();
    chk("rst0.keep", b0.RD1D, 32'hA5);
    chk("rst1.clear", b1.RD1D, 32'h0);
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      b1.StallD = ($urandom_range(0, 3) == 0);
      b1.FlushD = ($urandom_range(0, 3) == 0);
      b1.InstrF = $urandom;
      b1.PCPlus4F = $urandom;
      b1.RegWriteW = 1'($urandom);
      b1.WriteRegW = ($urandom_range(0, 1) == 0) ? b1.RsD : 5'($urandom);
      b1.ResultW = $urandom;
      b1.ForwardAD = 1'($urandom);
      b1.ForwardBD = 1'($urandom);
      b1.ALUMultOutM = ($urandom_range(0, 1) == 0) ? b1.RD2D : $urandom;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
